// File: rtl/alu_seq.sv
// alu_seq: registered 6502-style ALU with valid/ready handshake and sticky NZCV flags.
// Define ALU_BCD_EN to enable the decimal ADC/SBC correction (FIXUP) stage.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  mode,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [OP_W-1:0]  OP_ADC = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_SBC = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_ORA = OP_W'(3);
    localparam logic [OP_W-1:0]  OP_EOR = OP_W'(4);
    localparam logic [OP_W-1:0]  OP_ASL = OP_W'(5);
    localparam logic [OP_W-1:0]  OP_LSR = OP_W'(6);
    localparam logic [OP_W-1:0]  OP_ROL = OP_W'(7);
    localparam logic [OP_W-1:0]  OP_ROR = OP_W'(8);
    localparam logic [OP_W-1:0]  OP_CMP = OP_W'(9);
    localparam logic [OP_W-1:0]  OP_INC = OP_W'(10);
    localparam logic [OP_W-1:0]  OP_DEC = OP_W'(11);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r, b_r, alu_out_r;
    logic [OP_W-1:0]  mode_r;
    logic             cin_r, in_ready_r, out_valid_r;
    logic             n_r, z_r, c_r, v_r;

    logic [WIDTH-1:0] b_eff_s, res_s, flag_src_s;
    logic [WIDTH:0]   sum_s;
    logic             cin_eff_s, c_nx_s, v_nx_s, arith_v_s;
    logic             bcd_go_s, fx_n_s, fx_c_s, fx_v_s;
    logic [WIDTH-1:0] fx_res_s;

    // Operand conditioning: SBC and CMP add the complement of B; CMP forces carry-in.
    always_comb begin
        b_eff_s   = b_r;
        cin_eff_s = cin_r;
        if ((mode_r == OP_SBC) || (mode_r == OP_CMP)) begin
            b_eff_s = ~b_r;
        end else begin
            b_eff_s = b_r;
        end
        if (mode_r == OP_CMP) begin
            cin_eff_s = 1'b1;
        end else begin
            cin_eff_s = cin_r;
        end
    end

    assign sum_s     = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_eff_s};
    assign arith_v_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);

    // Binary result and next C/V; unaffected flags default to their held values.
    always_comb begin
        res_s  = a_r;
        c_nx_s = c_r;
        v_nx_s = v_r;
        case (mode_r)
            OP_ADC, OP_SBC: begin
                res_s  = sum_s[WIDTH-1:0];
                c_nx_s = sum_s[WIDTH];
                v_nx_s = arith_v_s;
            end
            OP_AND: res_s = a_r & b_r;
            OP_ORA: res_s = a_r | b_r;
            OP_EOR: res_s = a_r ^ b_r;
            OP_ASL: begin res_s = {a_r[WIDTH-2:0], 1'b0};  c_nx_s = a_r[WIDTH-1]; end
            OP_LSR: begin res_s = {1'b0, a_r[WIDTH-1:1]};  c_nx_s = a_r[0];       end
            OP_ROL: begin res_s = {a_r[WIDTH-2:0], cin_r}; c_nx_s = a_r[WIDTH-1]; end
            OP_ROR: begin res_s = {cin_r, a_r[WIDTH-1:1]}; c_nx_s = a_r[0];       end
            OP_CMP: begin res_s = a_r; c_nx_s = sum_s[WIDTH]; end
            OP_INC: res_s = a_r + ONE;
            OP_DEC: res_s = a_r - ONE;
            default: res_s = a_r;
        endcase
        if (mode_r == OP_CMP) begin
            flag_src_s = sum_s[WIDTH-1:0];
        end else begin
            flag_src_s = res_s;
        end
    end

`ifdef ALU_BCD_EN
    localparam int NIB = WIDTH / 4;

    logic             dec_r;
    logic [WIDTH-1:0] bin_r;
    logic [NIB-1:0]   hc_s, hc_r;

    assign bcd_go_s = dec_r && ((mode_r == OP_ADC) || (mode_r == OP_SBC));
    assign fx_n_s   = bin_r[WIDTH-1];
    assign fx_v_s   = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (bin_r[WIDTH-1] != a_r[WIDTH-1]);

    // Carry out of every nibble of the binary sum.
    always_comb begin
        logic [4:0] t;
        logic       c;
        hc_s = '0;
        t    = 5'd0;
        c    = cin_r;
        for (int i = 0; i < NIB; i++) begin
            t       = {1'b0, a_r[4*i +: 4]} + {1'b0, b_eff_s[4*i +: 4]} + {4'b0000, c};
            hc_s[i] = t[4];
            c       = t[4];
        end
    end

    // Rebuild each decimal digit from the binary nibble, swapping the binary carry for the decimal one.
    always_comb begin
        logic [4:0] raw;
        logic       dc, bc;
        fx_res_s = '0;
        fx_c_s   = 1'b0;
        raw      = 5'd0;
        dc       = cin_r;
        bc       = cin_r;
        for (int i = 0; i < NIB; i++) begin
            raw = {hc_r[i], bin_r[4*i +: 4]} - {4'b0000, bc} + {4'b0000, dc};
            if (mode_r == OP_SBC) begin
                if (raw[4]) begin
                    fx_res_s[4*i +: 4] = raw[3:0];
                    dc = 1'b1;
                end else begin
                    fx_res_s[4*i +: 4] = raw[3:0] - 4'd6;
                    dc = 1'b0;
                end
            end else begin
                if (raw > 5'd9) begin
                    fx_res_s[4*i +: 4] = raw[3:0] + 4'd6;
                    dc = 1'b1;
                end else begin
                    fx_res_s[4*i +: 4] = raw[3:0];
                    dc = 1'b0;
                end
            end
            bc = hc_r[i];
        end
        fx_c_s = dc;
    end

    // Decimal request and binary intermediate held for the FIXUP cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_r <= 1'b0;
            bin_r <= '0;
            hc_r  <= '0;
        end else begin
            if ((state_r == ST_IDLE) && in_valid) begin
                dec_r <= decimal;
            end
            if (state_r == ST_EXEC) begin
                bin_r <= sum_s[WIDTH-1:0];
                hc_r  <= hc_s;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = decimal;
    assign bcd_go_s = 1'b0;
    assign fx_res_s = '0;
    assign fx_n_s   = 1'b0;
    assign fx_c_s   = 1'b0;
    assign fx_v_s   = 1'b0;
`endif

    // Handshake FSM, operand capture and result/flag commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            mode_r      <= '0;
            cin_r       <= 1'b0;
            alu_out_r   <= '0;
            n_r         <= 1'b0;
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= alu_a;
                        b_r        <= alu_b;
                        mode_r     <= mode;
                        cin_r      <= carry_in;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bcd_go_s) begin
                        state_r <= ST_FIXUP;
                    end else begin
                        alu_out_r   <= res_s;
                        n_r         <= flag_src_s[WIDTH-1];
                        z_r         <= ~|flag_src_s;
                        c_r         <= c_nx_s;
                        v_r         <= v_nx_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_FIXUP: begin
                    alu_out_r   <= fx_res_s;
                    n_r         <= fx_n_s;
                    z_r         <= ~|fx_res_s;
                    c_r         <= fx_c_s;
                    v_r         <= fx_v_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign alu_out   = alu_out_r;
    assign flag_n    = n_r;
    assign flag_z    = z_r;
    assign flag_c    = c_r;
    assign flag_v    = v_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors on WIDTH=8 and WIDTH=16 instances.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, decimal = 1'b0, carry_in = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [3:0]  mode = 4'd0;
    logic [7:0]  alu_a = 8'h00, alu_b = 8'h00, alu_out;
    logic        flag_n, flag_z, flag_c, flag_v;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
    logic [3:0]  mode16 = 4'd0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000, out16;
    logic        n16, z16, c16, v16;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] val;
        logic        n, z, c, v;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pops8 = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .OP_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .alu_a(alu_a), .alu_b(alu_b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    alu_seq #(.WIDTH(16), .OP_W(4)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .mode(mode16), .alu_a(a16), .alu_b(b16), .carry_in(1'b0), .decimal(1'b0),
        .out_valid(out_valid16), .out_ready(out_ready16), .alu_out(out16),
        .flag_n(n16), .flag_z(z16), .flag_c(c16), .flag_v(v16)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (op %0d): got 0x%0h, expected 0x%0h", nm, id, act, want);
        end
    endtask

    // Monitor for the 8-bit instance: compare each consumed result against the queue head.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", alu_out);
            end else begin
                exp_t e;
                e = q8.pop_front();
                pops8++;
                chk("alu_out", int'(e.id), 32'(alu_out), 32'(e.val[7:0]));
                chk("flag_n",  int'(e.id), 32'(flag_n),  32'(e.n));
                chk("flag_z",  int'(e.id), 32'(flag_z),  32'(e.z));
                chk("flag_c",  int'(e.id), 32'(flag_c),  32'(e.c));
                chk("flag_v",  int'(e.id), 32'(flag_v),  32'(e.v));
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (reset_n && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result16: got 0x%0h with empty scoreboard", out16);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("alu_out16", int'(e.id), 32'(out16), 32'(e.val));
                chk("flag_n16",  int'(e.id), 32'(n16),   32'(e.n));
                chk("flag_z16",  int'(e.id), 32'(z16),   32'(e.z));
                chk("flag_c16",  int'(e.id), 32'(c16),   32'(e.c));
                chk("flag_v16",  int'(e.id), 32'(v16),   32'(e.v));
            end
        end
    end

    task automatic issue8(input int id, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic dc, input logic [7:0] ev,
                          input logic en, input logic ez, input logic ec, input logic evv, input int lat);
        int w;
        int n;
        exp_t e;
        @(posedge clk); #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout (op %0d): got 0, expected 1", id);
        end
        mode = m; alu_a = a; alu_b = b; carry_in = ci; decimal = dc; in_valid = 1'b1;
        e = '{id: 8'(id), val: {8'h00, ev}, n: en, z: ez, c: ec, v: evv};
        q8.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", id, 32'(n), 32'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int w;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_in_ready",  0, 32'(in_ready),  32'd1);
        chk("rst_alu_out",   0, 32'(alu_out),   32'd0);
        chk("rst_flags",     0, 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        //      id mode   a      b      ci    dc    out    N     Z     C     V    lat
        issue8( 1, 4'd0,  8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 2); // ADC
        issue8( 2, 4'd1,  8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2); // SBC
        issue8( 3, 4'd9,  8'h40, 8'h40, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 2); // CMP
        issue8( 4, 4'd8,  8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 2); // ROR
        issue8( 5, 4'd5,  8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2); // ASL
        issue8( 6, 4'd11, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 2); // DEC
        issue8( 7, 4'd10, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2); // INC
        issue8( 8, 4'd0,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 2); // ADC overflow
        issue8( 9, 4'd2,  8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2); // AND
        issue8(10, 4'd3,  8'h12, 8'h81, 1'b0, 1'b0, 8'h93, 1'b1, 1'b0, 1'b0, 1'b1, 2); // ORA
        issue8(11, 4'd4,  8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 2); // EOR
        issue8(12, 4'd6,  8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2); // LSR
        issue8(13, 4'd7,  8'h40, 8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 2); // ROL
        issue8(14, 4'd15, 8'h00, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2); // PASS
`ifdef ALU_BCD_EN
        issue8(15, 4'd0,  8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 3); // ADC decimal
        issue8(16, 4'd1,  8'h42, 8'h13, 1'b1, 1'b1, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 3); // SBC decimal
`else
        issue8(15, 4'd0,  8'h58, 8'h46, 1'b1, 1'b1, 8'h9F, 1'b1, 1'b0, 1'b0, 1'b1, 2); // decimal ignored
        issue8(16, 4'd1,  8'h42, 8'h13, 1'b1, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b1, 1'b0, 2); // decimal ignored
`endif

        // Backpressure: in_valid held high while the result is stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        mode = 4'd0; alu_a = 8'h01; alu_b = 8'h02; carry_in = 1'b0; decimal = 1'b0; in_valid = 1'b1;
        q8.push_back('{id: 8'd17, val: 16'h0003, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0});
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("stall_out_valid", 17, 32'(out_valid), 32'd1);
            chk("stall_in_ready",  17, 32'(in_ready),  32'd0);
            chk("stall_alu_out",   17, 32'(alu_out),   32'h03);
            chk("stall_flags",     17, 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
            @(negedge clk);
        end
        p0 = pops8;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (4) @(negedge clk);
        chk("consumed_once", 17, 32'(pops8 - p0), 32'd1);
        chk("post_release_idle", 17, 32'(in_ready), 32'd1);

        // Reset while the operation is in EXEC: nothing must come out.
        @(posedge clk); #1;
        mode = 4'd0; alu_a = 8'h7F; alu_b = 8'h01; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("midrst_out_valid", 18, 32'(out_valid), 32'd0);
        chk("midrst_alu_out",   18, 32'(alu_out),   32'd0);
        chk("midrst_flags",     18, 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        chk("midrst_in_ready",  18, 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("postrst_out_valid", 18, 32'(out_valid), 32'd0);
        chk("postrst_in_ready",  18, 32'(in_ready),  32'd1);
        issue8(19, 4'd0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // WIDTH=16 wrap-around.
        @(posedge clk); #1;
        mode16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
        q16.push_back('{id: 8'd20, val: 16'h0000, n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        w = 0;
        while (q16.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);

        chk("scoreboard8_drained",  0, 32'(q8.size()),  32'd0);
        chk("scoreboard16_drained", 0, 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 6502 combinational ALU. It adds a WIDTH parameter, shift/rotate/compare/inc/dec ops, a sticky NZCV flag register and a valid/ready handshake on input and output. An optional multi-cycle BCD correction stage supports decimal-mode ADC/SBC. It sits between the CPU decode/operand-fetch stage and the accumulator/status writeback path.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 4 (>= 8 and a multiple of 4 when BCD is enabled)
OP_W, 4, width of mode field

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/mode present
in_ready  output  1  block can accept an operation
mode  input  OP_W  opcode: 0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP, 10 INC, 11 DEC, others PASS
alu_a  input  WIDTH  operand A
alu_b  input  WIDTH  operand B (ignored by shifts, INC, DEC, PASS)
carry_in  input  1  carry / not-borrow in
decimal  input  1  BCD mode request for ADC/SBC
out_valid  output  1  result held and valid
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  registered result
flag_n  output  1  negative = alu_out[WIDTH-1]
flag_z  output  1  zero
flag_c  output  1  carry out
flag_v  output  1  signed overflow

Behaviour:
- Reset (async, reset_n=0): state IDLE; alu_out=0; all flags=0; out_valid=0; in_ready=1. A reset mid-operation discards that operation; no partial result is emitted.
- FSM: IDLE -> EXEC on in_valid&&in_ready (operands, mode, carry_in and decimal latched). EXEC -> FIXUP if BCD is active for ADC/SBC, else -> DONE. FIXUP -> DONE. DONE -> IDLE on out_ready.
- in_ready = (state==IDLE). No new accept in the cycle DONE exits, so accepted operations are spaced at least 3 cycles apart.
- out_valid = (state==DONE). alu_out and flags are stable while out_valid && !out_ready.
- Latency (accept edge to out_valid high): binary 2 cycles; BCD 3 cycles.
- Arithmetic, all mod 2^WIDTH with carry from bit WIDTH:
  - ADC: a+b+cin.
  - SBC: a+~b+cin (C=1 means no borrow).
  - V = (a[W-1]==b'[W-1]) && (res[W-1]!=a[W-1]), where b' = b for ADC and ~b for SBC.
- Logic ops (AND/ORA/EOR): C and V keep their previous register values.
- Shifts (rotates use carry_in):
  - ASL: C=a[W-1], res=a<<1.
  - LSR: C=a[0], res=a>>1.
  - ROL: res={a[W-2:0],cin}, C=a[W-1].
  - ROR: res={cin,a[W-1:1]}, C=a[0].
  - V keeps its previous value for all shifts.
- CMP: computes a+~b+1. C, Z, N from that difference; V keeps its previous value; alu_out = a (A is unmodified).
- INC/DEC: a±1, wraps (max->0, 0->max). C and V keep their previous values.
- PASS: res=a; flags keep their previous values except N and Z.
- Z = (res==0) and N = res[W-1] for every op; for CMP both come from the difference.
- Flags update only on the EXEC->DONE or FIXUP->DONE transition.

Optional Feature:
ALU_BCD_EN.
- Defined: when decimal=1 for ADC/SBC, EXEC computes the binary sum plus per-nibble half-carries, and FIXUP applies per-nibble +6 (ADC) or -6 (SBC) correction.
- C = decimal carry out of the top nibble. V and N come from the binary intermediate (NMOS behaviour); Z comes from the corrected result.
- Inputs with non-BCD nibbles give undefined data, but the handshake remains correct.
- Not defined: decimal is ignored, FIXUP is unreachable, and all ops use 2-cycle latency.

Test Plan:
- WIDTH=8, ADC a=0x50 b=0x50 cin=0 -> alu_out=0xA0, N=1 V=1 C=0 Z=0; out_valid 2 cycles after accept.
- SBC a=0x00 b=0x01 cin=1 -> 0xFF, C=0 N=1 V=0; then CMP a=0x40 b=0x40 -> alu_out=0x40, Z=1 C=1.
- ROR a=0x01 cin=1 -> 0x80, C=1 N=1; ASL a=0x80 -> 0x00, C=1 Z=1; DEC a=0x00 -> 0xFF, C unchanged.
- ALU_BCD_EN, ADC decimal a=0x58 b=0x46 cin=1 -> 0x05, C=1, out_valid 3 cycles after accept.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 -> alu_out/flags frozen, in_ready=0, exactly one result consumed on release.
- Reset: reset_n low during EXEC -> out_valid=0, flags=0, alu_out=0 immediately; in_ready=1 after release. WIDTH=16 ADC 0xFFFF+0x0001 -> 0x0000, C=1 Z=1.
